// File: rtl/probe_capture_buffer.sv
// probe_capture_buffer: selects one of NUM_CH probe channels through a
// registered selector and captures its valid samples into a DEPTH-entry
// buffer (free-run, triggered or single-shot). The buffer is drained through
// a FIFO-style read port.
module probe_capture_buffer #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                              inClock,
  input  logic                              inReset,
  input  logic [NUM_CH*DATA_W-1:0]          inProbe,
  input  logic [NUM_CH-1:0]                 inProbeValid,
  input  logic                              inCfgWrite,
  input  logic [$clog2(NUM_CH)-1:0]         inCfgSel,
  input  logic [1:0]                        inCfgMode,
  input  logic [DATA_W-1:0]                 inCfgTrig,
  input  logic                              inArm,
  input  logic                              inAbort,
  input  logic                              inReadEnable,
  output logic [DATA_W-1:0]                 outData,
  output logic                              outValid,
  output logic [DATA_W-1:0]                 outLiveData,
  output logic [$clog2(DEPTH):0]            outCount,
  output logic                              outEmpty,
  output logic                              outFull,
  output logic                              outOverflow,
  output logic [1:0]                        outState
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [SEL_W-1:0]    cfg_sel;
  logic [1:0]          cfg_mode;
  logic [DATA_W-1:0]   cfg_trig;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic [DATA_W-1:0]   live_q;

  logic                sample_valid;
  logic [DATA_W-1:0]   sample_data;
  logic                full;
  logic                empty;
  logic                cfg_open;
  logic                free_mode;
  logic                trig_mode;
  logic                arm_fire;
  logic                read_fire;
  logic                wr_fire;
  logic                drop;

  assign sample_valid = inProbeValid[cfg_sel];
  assign sample_data  = inProbe[int'(cfg_sel)*DATA_W +: DATA_W];
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign cfg_open     = (state == IDLE) || (state == DONE);
  assign free_mode    = (cfg_mode == 2'b00);
  assign trig_mode    = (cfg_mode == 2'b01);
  // Abort outranks arm; an arm clears the buffer so a same-cycle read is void.
  assign arm_fire     = inArm && !inAbort && cfg_open;
  assign read_fire    = inReadEnable && !empty && !arm_fire;

  // Next-state and write/drop decision for the capture sequencer.
  always_comb begin
    state_next = state;
    wr_fire    = 1'b0;
    drop       = 1'b0;
    if (inAbort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (inArm) state_next = trig_mode ? ARMED : CAPTURE;
        end
        ARMED: begin
          if (sample_valid && (sample_data == cfg_trig)) begin
            wr_fire    = 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            if (!full || read_fire) begin
              wr_fire = 1'b1;
              // Only a write that actually grows the count to DEPTH ends a shot.
              if (!free_mode && !read_fire && (count == CNT_W'(DEPTH - 1)))
                state_next = DONE;
            end else if (free_mode) begin
              drop = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) state <= IDLE;
    else          state <= state_next;
  end

  // Configuration registers, writable only while no capture is running.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      cfg_sel  <= '0;
      cfg_mode <= 2'b00;
      cfg_trig <= '0;
    end else if (inCfgWrite && cfg_open) begin
      cfg_sel  <= inCfgSel;
      cfg_mode <= inCfgMode;
      cfg_trig <= inCfgTrig;
    end
  end

  // Pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (arm_fire) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_fire)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (read_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_fire, read_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Capture RAM; contents need no reset because pointers define validity.
  always_ff @(posedge inClock) begin
    if (wr_fire) mem[wr_ptr] <= sample_data;
  end

  // Registered read port and live view of the selected channel.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      live_q  <= '0;
    end else begin
      valid_q <= read_fire;
      if (read_fire) data_q <= mem[rd_ptr];
      live_q  <= sample_data;
    end
  end

  assign outData     = data_q;
  assign outValid    = valid_q;
  assign outLiveData = live_q;
  assign outCount    = count;
  assign outEmpty    = empty;
  assign outFull     = full;
  assign outOverflow = overflow;
  assign outState    = state;

endmodule

// File: tb/tb_probe_capture_buffer.sv
// Directed bench for probe_capture_buffer with hand-computed expectations.
module tb_probe_capture_buffer;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;

  logic                     inClock;
  logic                     inReset;
  logic [NUM_CH*DATA_W-1:0] inProbe;
  logic [NUM_CH-1:0]        inProbeValid;
  logic                     inCfgWrite;
  logic [2:0]               inCfgSel;
  logic [1:0]               inCfgMode;
  logic [DATA_W-1:0]        inCfgTrig;
  logic                     inArm;
  logic                     inAbort;
  logic                     inReadEnable;
  logic [DATA_W-1:0]        outData;
  logic                     outValid;
  logic [DATA_W-1:0]        outLiveData;
  logic [4:0]               outCount;
  logic                     outEmpty;
  logic                     outFull;
  logic                     outOverflow;
  logic [1:0]               outState;

  int errors = 0;
  int checks = 0;

  probe_capture_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .inClock(inClock), .inReset(inReset), .inProbe(inProbe),
    .inProbeValid(inProbeValid), .inCfgWrite(inCfgWrite), .inCfgSel(inCfgSel),
    .inCfgMode(inCfgMode), .inCfgTrig(inCfgTrig), .inArm(inArm),
    .inAbort(inAbort), .inReadEnable(inReadEnable), .outData(outData),
    .outValid(outValid), .outLiveData(outLiveData), .outCount(outCount),
    .outEmpty(outEmpty), .outFull(outFull), .outOverflow(outOverflow),
    .outState(outState)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge inClock);
    #1;
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [1:0] mode, input logic [3:0] trig);
    inCfgWrite = 1'b1; inCfgSel = sel; inCfgMode = mode; inCfgTrig = trig;
    step();
    inCfgWrite = 1'b0;
  endtask

  task automatic arm();
    inArm = 1'b1;
    step();
    inArm = 1'b0;
  endtask

  task automatic abort();
    inAbort = 1'b1;
    step();
    inAbort = 1'b0;
  endtask

  // Sample only on channel ch.
  task automatic sample(input int ch, input logic [3:0] d);
    inProbe = '0;
    inProbe[ch*DATA_W +: DATA_W] = d;
    inProbeValid = '0;
    inProbeValid[ch] = 1'b1;
    step();
    inProbe = '0; inProbeValid = '0;
  endtask

  // All channels valid; unselected channels carry 4'hF.
  task automatic sample_all(input int ch, input logic [3:0] d);
    inProbe = '1;
    inProbe[ch*DATA_W +: DATA_W] = d;
    inProbeValid = '1;
    step();
    inProbe = '0; inProbeValid = '0;
  endtask

  // Valid on every channel except ch.
  task automatic others_only(input int ch);
    inProbe = '1;
    inProbeValid = '1;
    inProbeValid[ch] = 1'b0;
    step();
    inProbe = '0; inProbeValid = '0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] exp);
    inReadEnable = 1'b1;
    step();
    inReadEnable = 1'b0;
    check({tag, "_valid"}, outValid, 1);
    check({tag, "_data"}, outData, exp);
  endtask

  initial begin
    inReset = 1'b0; inProbe = '0; inProbeValid = '0; inCfgWrite = 1'b0;
    inCfgSel = '0; inCfgMode = '0; inCfgTrig = '0; inArm = 1'b0;
    inAbort = 1'b0; inReadEnable = 1'b0;
    #12 inReset = 1'b1;
    step();

    // Reset values
    check("rst_state", outState, 0);
    check("rst_count", outCount, 0);
    check("rst_empty", outEmpty, 1);
    check("rst_full", outFull, 0);
    check("rst_ovf", outOverflow, 0);
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 0);
    check("rst_live", outLiveData, 0);

    // 1. Free-run overflow
    cfg(3'd2, 2'b00, 4'h0);
    arm();
    check("fr_state", outState, 2);
    for (int i = 0; i < 20; i++) sample(2, 4'(i % 4));
    check("fr_full", outFull, 1);
    check("fr_ovf", outOverflow, 1);
    check("fr_count", outCount, 16);
    for (int i = 0; i < 16; i++) read_chk($sformatf("fr_rd%0d", i), 4'(i % 4));
    check("fr_empty", outEmpty, 1);
    check("fr_count0", outCount, 0);
    inReadEnable = 1'b1; step(); inReadEnable = 1'b0;
    check("fr_empty_rd", outValid, 0);
    abort();
    check("fr_abort", outState, 0);

    // 2. Trigger
    cfg(3'd3, 2'b01, 4'hA);
    arm();
    check("tr_armed", outState, 1);
    sample(3, 4'h1);
    sample(3, 4'h2);
    check("tr_still_armed", outState, 1);
    check("tr_nomatch_cnt", outCount, 0);
    sample(3, 4'hA);
    check("tr_capture", outState, 2);
    check("tr_cnt1", outCount, 1);
    sample(3, 4'hB);
    sample(3, 4'hC);
    check("tr_cnt3", outCount, 3);
    read_chk("tr_rd0", 4'hA);
    read_chk("tr_rd1", 4'hB);
    read_chk("tr_rd2", 4'hC);
    abort();

    // 3. Single-shot with noise on other channels
    cfg(3'd1, 2'b10, 4'h0);
    arm();
    check("ss_state", outState, 2);
    for (int i = 0; i < 18; i++) begin
      sample_all(1, 4'(i % 15));
      if (i < 4) others_only(1);
      if (i == 14) check("ss_not_done", outState, 2);
      if (i == 15) check("ss_done", outState, 3);
    end
    check("ss_done_hold", outState, 3);
    check("ss_count", outCount, 16);
    check("ss_full", outFull, 1);
    check("ss_ovf", outOverflow, 0);
    for (int i = 0; i < 16; i++) read_chk($sformatf("ss_rd%0d", i), 4'(i % 15));
    check("ss_empty", outEmpty, 1);

    // 4. Config lock during capture
    cfg(3'd2, 2'b00, 4'h0);
    arm();
    cfg(3'd5, 2'b00, 4'h0);
    inProbe = '0;
    inProbe[2*DATA_W +: DATA_W] = 4'h7;
    inProbe[5*DATA_W +: DATA_W] = 4'h9;
    step();
    check("lock_live", outLiveData, 4'h7);
    abort();
    cfg(3'd5, 2'b00, 4'h0);
    check("cfg_edge_live", outLiveData, 4'h7);
    step();
    check("cfg_new_live", outLiveData, 4'h9);
    inProbe = '0;

    // 5. Full plus read in free-run
    arm();
    for (int i = 0; i < 16; i++) sample(5, 4'((i + 5) % 16));
    check("fw_count16", outCount, 16);
    inReadEnable = 1'b1;
    sample(5, 4'h3);
    inReadEnable = 1'b0;
    check("fw_count_hold", outCount, 16);
    check("fw_ovf", outOverflow, 0);
    check("fw_valid", outValid, 1);
    check("fw_oldest", outData, 4'h5);
    read_chk("fw_rd1", 4'h6);
    abort();

    // Arm and read together: the arm wins
    inArm = 1'b1; inReadEnable = 1'b1;
    step();
    inArm = 1'b0; inReadEnable = 1'b0;
    check("armrd_valid", outValid, 0);
    check("armrd_count", outCount, 0);
    check("armrd_state", outState, 2);

    // 6. Async reset mid-capture
    for (int i = 0; i < 7; i++) sample(5, 4'(i + 1));
    check("ar_count7", outCount, 7);
    #2 inReset = 1'b0;
    #1;
    check("ar_state", outState, 0);
    check("ar_empty", outEmpty, 1);
    check("ar_count", outCount, 0);
    check("ar_data", outData, 0);
    check("ar_live", outLiveData, 0);
    #3 inReset = 1'b1;
    inReadEnable = 1'b1;
    step();
    step();
    inReadEnable = 1'b0;
    check("ar_empty_rd", outValid, 0);
    check("ar_empty_after", outEmpty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/probe_capture_buffer.md
Name: probe_capture_buffer

Overview:
- Parametrised successor to the fixed test mux/demux observation network in the MSK transceiver top.
- Selects one of NUM_CH probe channels (coder, decoder, CORDIC, CDR, FIFO taps) through a registered runtime selector.
- Captures valid samples of that channel into a DEPTH-entry buffer, in free-run, triggered or single-shot mode.
- The buffer is read back through a FIFO-style read port, so post-silicon debug does not need one package pin per signal.

Parameters:
NUM_CH, 8, number of probe channels; >=2.
DATA_W, 4, bits per probe channel.
DEPTH, 16, capture buffer entries; power of two, >=2.

Ports:
inClock  in  1  single clock, rising edge.
inReset  in  1  asynchronous, active-low reset.
inProbe  in  NUM_CH*DATA_W  concatenated channels; channel k is bits [k*DATA_W +: DATA_W].
inProbeValid  in  NUM_CH  per-channel sample strobe.
inCfgWrite  in  1  load inCfgSel/inCfgMode/inCfgTrig into config registers.
inCfgSel  in  clog2(NUM_CH)  channel select.
inCfgMode  in  2  00 free-run, 01 trigger, 10 single-shot, 11 reserved (treated as 10).
inCfgTrig  in  DATA_W  trigger match value.
inArm  in  1  start a capture.
inAbort  in  1  stop the capture and return to IDLE.
inReadEnable  in  1  pop one buffer entry.
outData  out  DATA_W  popped entry.
outValid  out  1  outData valid, one-cycle pulse.
outLiveData  out  DATA_W  registered copy of the selected channel.
outCount  out  clog2(DEPTH)+1  entries held.
outEmpty  out  1  outCount==0.
outFull  out  1  outCount==DEPTH.
outOverflow  out  1  sticky: a sample was dropped in free-run.
outState  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state IDLE; config sel=0, mode=00, trig=0.
  - Pointers and outCount 0; outEmpty=1; all other outputs 0.
  - Buffer RAM contents are don't-care.
- Config: inCfgWrite is honoured only in IDLE or DONE and ignored in ARMED/CAPTURE. New values take effect the next cycle.
- "Sample" means inProbeValid[sel]=1; data is the inProbe slice for sel. Only the selected channel is ever written.
- outLiveData: register of the selected slice, updated every cycle regardless of valid; 1-cycle latency.
- State machine:
  - IDLE, inArm=1: clear wr/rd pointers, outCount and outOverflow. Go to ARMED if mode=01, otherwise go to CAPTURE.
  - DONE, inArm=1: same as from IDLE.
  - ARMED: a sample whose data equals trig is written to the buffer (it becomes the first entry) and state goes to CAPTURE. Non-matching samples are discarded.
  - CAPTURE, mode 00: every sample is written. When full and no read in the same cycle, the sample is dropped and outOverflow=1. State stays CAPTURE until inAbort.
  - CAPTURE, modes 01/10: every sample is written. The write that makes outCount==DEPTH moves state to DONE in the same edge.
  - DONE: no writes; reads allowed.
  - inAbort=1 in any state: go to IDLE next cycle. Buffer contents, pointers and overflow are kept. inAbort beats inArm.
  - inArm in ARMED/CAPTURE is ignored.
- Write timing:
  - A sample is stored on the edge where it is presented.
  - outCount/outEmpty/outFull update on that same edge, so the entry is readable the following cycle.
- Read timing:
  - inReadEnable with outEmpty=0: outData is registered and outValid=1 on the next cycle; rd pointer and count update.
  - inReadEnable with outEmpty=1 is ignored: outValid=0, outData holds its last value.
- Simultaneous write and read:
  - Both occur and outCount is unchanged.
  - At full in mode 00, the write is accepted and no overflow is flagged.
  - At full in modes 01/10, state is already DONE, so no write occurs.
- Simultaneous inArm and inReadEnable (IDLE/DONE): the arm wins, the buffer clears, and the read is ignored with outValid=0.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. outCount saturates at DEPTH and never wraps.
- Reset asserted mid-capture: immediate return to reset values. No partial write survives the reset.

Test Plan:
1. Free-run overflow: sel=2, mode 00, arm, then 20 samples 0..3 repeating.
   -> outFull=1, outOverflow=1, outCount=16.
   -> 16 reads return the first 16 samples in order, then outEmpty=1.
2. Trigger: sel=3, mode 01, trig=4'hA, samples 1,2,A,B,C.
   -> outState goes 01 then 10 on the A edge.
   -> outCount=3; reads return A, B, C.
3. Single-shot: mode 10, 18 samples on the selected channel plus valid activity on other channels.
   -> DONE after the 16th sample; samples 17-18 ignored; outFull=1, outOverflow=0.
   -> No data from unselected channels is stored.
4. Config lock: inCfgWrite sel=5 while in CAPTURE.
   -> Selector stays unchanged.
   -> The same write after inAbort takes effect: outLiveData follows channel 5 one cycle later.
5. Full plus read in free-run: at outCount=16, read and sample in the same cycle.
   -> outCount stays 16, outOverflow stays 0, outValid=1 the next cycle with the oldest entry.
6. Async reset mid-capture: pull inReset low between edges with outCount=7.
   -> All outputs reach reset values immediately: outState=00, outEmpty=1, outCount=0.
   -> Empty reads afterwards give outValid=0.
